// File: rtl/window_sum_pkg.sv
// Shared definitions for the window-sum decoder.
// Holds the default geometry, the fill/steady state encoding and the modular
// decode step. Exports: WINDOW_DEFAULT, SAMPLE_W_DEFAULT, SUM_W_DEFAULT, CALC_W, state_t, decode_step().
package window_sum_pkg;

  localparam int WINDOW_DEFAULT   = 4;
  localparam int SAMPLE_W_DEFAULT = 2;
  localparam int SUM_W_DEFAULT    = 2;

  // Working width of the decode arithmetic; callers keep the low bits they need.
  localparam int CALC_W = 32;

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_STEADY = 1'b1
  } state_t;

  // One decode step: sum - prev_sum + oldest, reduced mod 2^sum_w.
  // Because the result is only ever truncated further, the low bits are exact
  // even though the subtraction may borrow out of the top of CALC_W.
  function automatic logic [CALC_W-1:0] decode_step(
    input logic [CALC_W-1:0] sum,
    input logic [CALC_W-1:0] prev_sum,
    input logic [CALC_W-1:0] oldest,
    input int                sum_w
  );
    logic [CALC_W-1:0] mask;
    mask = (sum_w >= CALC_W) ? '1 : ((CALC_W'(1) << sum_w) - CALC_W'(1));
    return (sum - prev_sum + oldest) & mask;
  endfunction

endpackage

// File: rtl/window_sum_decoder_if.sv
// Sum-link receive bus: incoming window sums and the recovered sample outputs.
// Signals: in_valid, sum_x/y/t (toward decoder); out_valid, x/y/t_out (from decoder).
// master = the side feeding sums, slave = the decoder.
interface window_sum_decoder_if #(
  parameter int SAMPLE_W = 2,
  parameter int SUM_W    = 2
);
  logic                in_valid;
  logic [SUM_W-1:0]    sum_x;
  logic [SUM_W-1:0]    sum_y;
  logic [SUM_W-1:0]    sum_t;
  logic                out_valid;
  logic [SAMPLE_W-1:0] x_out;
  logic [SAMPLE_W-1:0] y_out;
  logic [SAMPLE_W-1:0] t_out;

  modport master (
    output in_valid, sum_x, sum_y, sum_t,
    input  out_valid, x_out, y_out, t_out
  );

  modport slave (
    input  in_valid, sum_x, sum_y, sum_t,
    output out_valid, x_out, y_out, t_out
  );
endinterface

// File: rtl/window_sum_decoder_chan.sv
// Single-channel window-sum decoder: previous sum, sample history, decode datapath.
// Ports: clk, rst_n (async, active-high), clear, load (decode this cycle), sum in,
// sample out (registered; holds between loads and across clear).
module window_sum_chan
  import window_sum_pkg::*;
#(
  parameter int WINDOW   = WINDOW_DEFAULT,
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int SUM_W    = SUM_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                load,
  input  logic [SUM_W-1:0]    sum,
  output logic [SAMPLE_W-1:0] sample
);

  logic [SUM_W-1:0]           prev_sum;
  // hist[0] is the oldest sample, the one leaving the window on the next decode.
  logic [SAMPLE_W-1:0]        hist [WINDOW];

  logic [CALC_W-1:0]          d_full;
  logic [CALC_W-SAMPLE_W-1:0] d_unused;
  logic [SAMPLE_W-1:0]        d_sample;

  assign d_full = decode_step(CALC_W'(sum), CALC_W'(prev_sum), CALC_W'(hist[0]), SUM_W);
  // Only the low SAMPLE_W bits form the recovered sample.
  assign {d_unused, d_sample} = d_full;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      prev_sum <= '0;
      sample   <= '0;
      for (int i = 0; i < WINDOW; i++) hist[i] <= '0;
    end else if (clear) begin
      // Restart history to match a freshly reset encoder; sample keeps its value.
      prev_sum <= '0;
      for (int i = 0; i < WINDOW; i++) hist[i] <= '0;
    end else if (load) begin
      prev_sum <= sum;
      for (int i = 0; i < WINDOW - 1; i++) hist[i] <= hist[i+1];
      hist[WINDOW-1] <= d_sample;
      sample         <= d_sample;
    end
  end

endmodule

// File: rtl/window_sum_decoder.sv
// Three-channel (x, y, t) inverse of the moving-window sum encoder.
// Ports: clk, rst_n (async, active-high), clear (sync restart), bus (slave: sums in,
// samples out, one-cycle latency, no backpressure), primed, sample_count.
module window_sum_decoder
  import window_sum_pkg::*;
#(
  parameter int WINDOW   = WINDOW_DEFAULT,
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int SUM_W    = SUM_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  window_sum_decoder_if.slave  bus,
  output logic                 primed,
  output logic [3:0]           sample_count
);

  localparam logic [3:0] WIN_CNT = 4'(WINDOW);

  state_t     state;
  state_t     state_d;
  logic [3:0] count_d;
  logic       load;
  logic       out_valid_q;

  // clear takes priority: a sum arriving with clear is dropped.
  assign load = bus.in_valid & ~clear;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state        <= ST_FILL;
      sample_count <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state        <= state_d;
      sample_count <= count_d;
      out_valid_q  <= load;
    end
  end

  always_comb begin
    state_d = state;
    count_d = sample_count;
    if (clear) begin
      state_d = ST_FILL;
      count_d = '0;
    end else if (load) begin
      case (state)
        ST_FILL: begin
          count_d = sample_count + 4'd1;
          if (sample_count + 4'd1 == WIN_CNT) state_d = ST_STEADY;
        end
        // Count stays saturated at WINDOW once steady.
        ST_STEADY: state_d = ST_STEADY;
        default:   state_d = ST_FILL;
      endcase
    end
  end

  assign primed        = (state == ST_STEADY);
  assign bus.out_valid = out_valid_q;

  window_sum_chan #(.WINDOW(WINDOW), .SAMPLE_W(SAMPLE_W), .SUM_W(SUM_W)) u_chan_x (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .sum(bus.sum_x), .sample(bus.x_out)
  );

  window_sum_chan #(.WINDOW(WINDOW), .SAMPLE_W(SAMPLE_W), .SUM_W(SUM_W)) u_chan_y (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .sum(bus.sum_y), .sample(bus.y_out)
  );

  window_sum_chan #(.WINDOW(WINDOW), .SAMPLE_W(SAMPLE_W), .SUM_W(SUM_W)) u_chan_t (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .sum(bus.sum_t), .sample(bus.t_out)
  );

endmodule

// File: tb/tb_window_sum_decoder.sv
// Testbench for window_sum_decoder: directed vectors plus an encoder-model regression.
// Expected samples are queued at issue time; a monitor pops them on each out_valid.
module tb_window_sum_decoder;

  localparam int W    = 4;
  localparam int SW   = 2;
  localparam int SUMW = 2;
  localparam int MASK = (1 << SUMW) - 1;

  typedef struct {
    int x;
    int y;
    int t;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       primed;
  logic [3:0] sample_count;

  window_sum_decoder_if #(.SAMPLE_W(SW), .SUM_W(SUMW)) bus ();

  window_sum_decoder #(.WINDOW(W), .SAMPLE_W(SW), .SUM_W(SUMW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
    .primed(primed), .sample_count(sample_count)
  );

  exp_t sb[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   n_pulse = 0;

  int basic_sum[5] = '{1, 3, 2, 2, 2};
  int basic_exp[5] = '{1, 2, 3, 0, 1};
  int gap_exp[4]   = '{2, 0, 0, 0};
  int rst_tsum[6]  = '{1, 2, 3, 0, 1, 3};
  int rst_texp[6]  = '{1, 1, 1, 1, 2, 3};
  int rst_xexp[6]  = '{0, 0, 0, 3, 0, 0};
  int t3_sum[5]    = '{3, 2, 1, 0, 0};

  int enc_h[3][W];
  int enc_s[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic drive(input bit v, input bit clr, input int sx, input int sy, input int st);
    bus.in_valid = v;
    clear        = clr;
    bus.sum_x    = SUMW'(sx);
    bus.sum_y    = SUMW'(sy);
    bus.sum_t    = SUMW'(st);
  endtask

  task automatic push(input int x, input int y, input int t);
    exp_t e;
    e.x = x; e.y = y; e.t = t;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0);
    end
  endtask

  task automatic enc_reset();
    for (int c = 0; c < 3; c++) begin
      enc_s[c] = 0;
      for (int i = 0; i < W; i++) enc_h[c][i] = 0;
    end
  endtask

  // Reference encoder: running window sum mod 2^SUMW over the last W samples.
  task automatic enc_push(input int c, input int s, output int sum);
    enc_s[c] = (enc_s[c] + s - enc_h[c][0]) & MASK;
    for (int i = 0; i < W - 1; i++) enc_h[c][i] = enc_h[c][i+1];
    enc_h[c][W-1] = s;
    sum = enc_s[c];
  endtask

  // Monitor: every out_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      n_pulse++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_out_valid: got=1 required=0 (queue empty)");
      end else begin
        exp_t e;
        int   got;
        int   req;
        e   = sb.pop_front();
        got = (int'(bus.x_out) << 8) | (int'(bus.y_out) << 4) | int'(bus.t_out);
        req = (e.x << 8) | (e.y << 4) | e.t;
        chk("sample_xyt(hex x_y_t)", got, req);
      end
    end
  end

  initial begin
    int p0;
    int sx, sy, st;
    int s[3];
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_x_out", int'(bus.x_out), 0);
    chk("rst_primed", int'(primed), 0);
    chk("rst_count", int'(sample_count), 0);
    rst_n = 1'b0;

    // Basic back-to-back decode with priming checks along the way.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("fill_count", int'(sample_count), (i < W) ? i : W);
        chk("fill_primed", int'(primed), (i >= W) ? 1 : 0);
      end
      drive(1, 0, basic_sum[i], 0, 0);
      push(basic_exp[i], 0, 0);
    end
    idle(1);
    chk("sat_count", int'(sample_count), 4);
    chk("sat_primed", int'(primed), 1);

    // Clear alone: history gone, outputs hold.
    @(negedge clk);
    drive(0, 1, 0, 0, 0);
    idle(1);
    chk("clr_count", int'(sample_count), 0);
    chk("clr_primed", int'(primed), 0);
    chk("clr_out_valid", int'(bus.out_valid), 0);
    chk("clr_x_hold", int'(bus.x_out), 1);

    // Gapped stream on y.
    p0 = n_pulse;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 0, 0, 2, 0);
      push(0, gap_exp[i], 0);
      idle(1);
      for (int j = 0; j < 2; j++) begin
        idle(1);
        chk("gap_out_valid", int'(bus.out_valid), 0);
        chk("gap_y_hold", int'(bus.y_out), gap_exp[i]);
      end
    end
    chk("gap_pulses", n_pulse - p0, 4);

    // Clear and in_valid together: sample dropped.
    @(negedge clk);
    drive(1, 1, 3, 0, 0);
    idle(1);
    chk("clrv_out_valid", int'(bus.out_valid), 0);
    chk("clrv_count", int'(sample_count), 0);
    chk("clrv_primed", int'(primed), 0);
    @(negedge clk);
    drive(1, 0, 3, 0, 0);
    push(3, 0, 0);

    // Six decodes, then an async reset pulse between clock edges.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1, 0, 3, 0, rst_tsum[i]);
      push(rst_xexp[i], 0, rst_texp[i]);
    end
    idle(1);
    chk("pre_rst_primed", int'(primed), 1);
    #2 rst_n = 1'b1;
    #1;
    chk("arst_t_out", int'(bus.t_out), 0);
    chk("arst_primed", int'(primed), 0);
    chk("arst_count", int'(sample_count), 0);
    chk("arst_out_valid", int'(bus.out_valid), 0);
    #1 rst_n = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, 0, 0, 0, t3_sum[i]);
      push(0, 0, 3);
    end
    idle(2);

    // Random regression against the reference encoder.
    @(negedge clk);
    drive(0, 1, 0, 0, 0);
    enc_reset();
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk);
        drive($urandom_range(0, 1) == 1, 1, $urandom_range(0, MASK),
              $urandom_range(0, MASK), $urandom_range(0, MASK));
        enc_reset();
      end
      for (int c = 0; c < 3; c++) s[c] = $urandom_range(0, (1 << SW) - 1);
      enc_push(0, s[0], sx);
      enc_push(1, s[1], sy);
      enc_push(2, s[2], st);
      @(negedge clk);
      drive(1, 0, sx, sy, st);
      push(s[0], s[1], s[2]);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(3);
    chk("queue_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
